// File: rtl/qdec_pkg.sv
// Shared definitions for the quadrature decoder: step codes, Gray phases,
// default parameter values and the phase-transition classifier.
package qdec_pkg;

    // Classification of one filtered {A,B} transition
    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_FWD  = 2'b01,
        STEP_REV  = 2'b10,
        STEP_ERR  = 2'b11
    } step_e;

    // Gray phases as {A,B}; forward order is 00 -> 10 -> 11 -> 01 -> 00
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    localparam int DEF_POS_W         = 24;
    localparam int DEF_VEL_W         = 16;
    localparam int DEF_SAMPLE_CYCLES = 100000;
    localparam int DEF_FILT_LEN      = 4;

    // Classify a move from the previous phase to the current phase
    function automatic step_e step_code(input logic [1:0] prev, input logic [1:0] curr);
        step_e code;
        case ({prev, curr})
            {PH_00, PH_10}, {PH_10, PH_11}, {PH_11, PH_01}, {PH_01, PH_00}: code = STEP_FWD;
            {PH_00, PH_01}, {PH_01, PH_11}, {PH_11, PH_10}, {PH_10, PH_00}: code = STEP_REV;
            {PH_00, PH_00}, {PH_10, PH_10}, {PH_11, PH_11}, {PH_01, PH_01}: code = STEP_NONE;
            default:                                                         code = STEP_ERR;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/qdec_filter.sv
// One encoder channel input path: 2-FF synchroniser followed by a debounce
// filter that only follows the synchronised level after it has differed from
// the filtered level for FILT_LEN consecutive clocks.
module qdec_filter
    import qdec_pkg::*;
#(
    parameter int FILT_LEN = DEF_FILT_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_filt
);

    localparam int CNT_W = $clog2(FILT_LEN + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_filt;
    logic [CNT_W-1:0] r_cnt;

    // Bring the asynchronous pin into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive disagreeing clocks; any agreement restarts the run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else if (r_sync2 == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt == CNT_W'(FILT_LEN - 1)) begin
            r_filt <= r_sync2;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/quadrature_counter.sv
// 4x quadrature decoder: filtered A/B channels are decoded into a wrapping
// signed position, a saturated per-window velocity, step/direction strobes,
// a sticky illegal-transition flag and a registered position==target compare.
// Optional index channel is enabled by defining QDEC_INDEX_EN.
module quadrature_counter
    import qdec_pkg::*;
#(
    parameter int POS_W         = DEF_POS_W,
    parameter int VEL_W         = DEF_VEL_W,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int FILT_LEN      = DEF_FILT_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_in,
    input  logic                    b_in,
    input  logic                    clr,
    input  logic                    err_clr,
    input  logic signed [POS_W-1:0] target,
    output logic signed [POS_W-1:0] position,
    output logic signed [VEL_W-1:0] velocity,
    output logic                    vel_valid,
    output logic                    step,
    output logic                    dir,
    output logic                    err,
`ifdef QDEC_INDEX_EN
    input  logic                    z_in,
    output logic                    index_seen,
`endif
    output logic                    at_target
);

    localparam int WIN_W   = $clog2(SAMPLE_CYCLES);
    // Accumulator must hold a full window of steps and be wider than VEL_W
    localparam int ACC_RAW = $clog2(SAMPLE_CYCLES + 1) + 1;
    localparam int ACC_W   = (ACC_RAW > VEL_W) ? ACC_RAW : VEL_W + 1;
    localparam logic signed [ACC_W-1:0] VEL_MAX = ACC_W'((64'sd1 <<< (VEL_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] VEL_MIN = ~VEL_MAX;

    // Clamp a window accumulation into the signed VEL_W range
    function automatic logic signed [VEL_W-1:0] sat_vel(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] c;
        if (v > VEL_MAX)      c = VEL_MAX;
        else if (v < VEL_MIN) c = VEL_MIN;
        else                  c = v;
        return c[VEL_W-1:0];
    endfunction

    logic                    w_a;
    logic                    w_b;
    logic [1:0]              w_ab;
    logic [1:0]              r_prev;
    step_e                   w_code;
    logic                    w_fwd;
    logic                    w_rev;
    logic                    w_z_rise;
    logic signed [ACC_W-1:0] w_delta;
    logic                    w_last;

    logic signed [POS_W-1:0] r_position;
    logic                    r_step;
    logic                    r_dir;
    logic                    r_err;
    logic                    r_at_target;
    logic [WIN_W-1:0]        r_win;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [VEL_W-1:0] r_velocity;
    logic                    r_vel_valid;

    qdec_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (a_in),
        .o_filt (w_a)
    );

    qdec_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (b_in),
        .o_filt (w_b)
    );

`ifdef QDEC_INDEX_EN
    logic w_z;
    logic r_z_prev;
    logic r_index_seen;

    qdec_filter #(.FILT_LEN(FILT_LEN)) u_filt_z (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (z_in),
        .o_filt (w_z)
    );

    assign w_z_rise = w_z & ~r_z_prev;

    // Track filtered Z for edge detection and latch that an index was seen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_z_prev     <= 1'b0;
            r_index_seen <= 1'b0;
        end else begin
            r_z_prev <= w_z;
            if (w_z_rise)     r_index_seen <= 1'b1;
            else if (err_clr) r_index_seen <= 1'b0;
        end
    end

    assign index_seen = r_index_seen;
`else
    assign w_z_rise = 1'b0;
`endif

    assign w_ab   = {w_a, w_b};
    assign w_code = step_code(r_prev, w_ab);
    assign w_fwd  = (w_code == STEP_FWD);
    assign w_rev  = (w_code == STEP_REV);
    assign w_last = (r_win == WIN_W'(SAMPLE_CYCLES - 1));

    // Signed contribution of this cycle's edge to the velocity window
    always_comb begin
        w_delta = '0;
        if (w_fwd)      w_delta = ACC_W'(1);
        else if (w_rev) w_delta = ACC_W'(-1);
    end

    // Remember the filtered phase so the next cycle can classify its move
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_prev <= PH_00;
        else     r_prev <= w_ab;
    end

    // Position, step strobe and direction; clr beats index beats step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_position <= '0;
            r_step     <= 1'b0;
            r_dir      <= 1'b0;
        end else begin
            r_step <= w_fwd | w_rev;
            if (w_fwd)      r_dir <= 1'b1;
            else if (w_rev) r_dir <= 1'b0;
            if (clr)           r_position <= '0;
            else if (w_z_rise) r_position <= '0;
            else if (w_fwd)    r_position <= r_position + POS_W'(1);
            else if (w_rev)    r_position <= r_position - POS_W'(1);
        end
    end

    // Sticky illegal-transition flag; a new error wins over err_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_err <= 1'b0;
        else if (w_code == STEP_ERR) r_err <= 1'b1;
        else if (err_clr)            r_err <= 1'b0;
    end

    // Registered target compare, one clock behind position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_at_target <= 1'b0;
        else     r_at_target <= (r_position == target);
    end

    // Velocity window: publish on the last cycle and restart with its edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win       <= '0;
            r_acc       <= '0;
            r_velocity  <= '0;
            r_vel_valid <= 1'b0;
        end else if (w_last) begin
            r_win       <= '0;
            r_acc       <= w_delta;
            r_velocity  <= sat_vel(r_acc);
            r_vel_valid <= 1'b1;
        end else begin
            r_win       <= r_win + WIN_W'(1);
            r_acc       <= r_acc + w_delta;
            r_vel_valid <= 1'b0;
        end
    end

    assign position  = r_position;
    assign velocity  = r_velocity;
    assign vel_valid = r_vel_valid;
    assign step      = r_step;
    assign dir       = r_dir;
    assign err       = r_err;
    assign at_target = r_at_target;

endmodule
